fetch_unit: RTL and testbench

- Fetch stage of the single-cycle RV32I core; sits directly upstream of instruction_memory.
- Owns the program counter and drives the memory's combinational byte address.
- Captures the returned 32-bit word into a registered output slot, with a valid/ready handshake toward decode.
- Accepts redirects from branch/jump resolution and supports halt and stall.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage of the single-cycle RV32I core.
// Owns the PC, drives the combinational instruction-memory address and
// registers the returned word into an output slot with a valid/ready
// handshake toward decode. Supports redirect, halt and stall.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap).
module fetch_unit #(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DW       = 32,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter logic [DW-1:0]  NOP_INST = DW'(32'h0000_0013)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_inst,
  output logic [AW-1:0] out_pc,
  output logic          halted,
  output logic [31:0]   fetch_count,
  output logic          trap_valid,
  output logic [AW-1:0] trap_pc
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT, FETCH, HALTED, TRAP} state_t;
`else
  typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;
`endif

  state_t        state;
  logic [AW-1:0] pc;
  logic          fire;
  logic          free;

  assign imem_addr = pc;
  assign halted    = (state == HALTED);
  assign fire      = out_valid && out_ready;
  assign free      = !out_valid || out_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic          trap_q;
  logic [AW-1:0] trap_pc_q;
  logic          misaligned;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign trap_valid = trap_q;
  assign trap_pc    = trap_pc_q;
`else
  assign trap_valid = 1'b0;
  assign trap_pc    = '0;
`endif

  // PC, output slot, state and accepted-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_inst    <= NOP_INST;
      out_pc      <= '0;
      fetch_count <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
      trap_pc_q   <= '0;
`endif
    end else begin
      // a redirect flushes the slot, so a same-cycle handshake is not counted
      if (fire && !redirect_valid) begin
        fetch_count <= fetch_count + 32'd1;
      end

      unique case (state)
        BOOT: begin
          state <= halt_req ? HALTED : FETCH;
        end

        // FETCH and HALTED share redirect and drain handling; only FETCH
        // without halt_req captures a new word.
        FETCH, HALTED: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            out_inst  <= NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              state     <= TRAP;
              trap_q    <= 1'b1;
              trap_pc_q <= redirect_pc;
            end else begin
              pc <= redirect_pc;
            end
`else
            pc <= redirect_pc & ~AW'(3);
`endif
          end else if (halt_req || state == HALTED) begin
            state <= halt_req ? HALTED : FETCH;
            if (fire) begin
              out_valid <= 1'b0;
              out_inst  <= NOP_INST;
            end
          end else if (free) begin
            out_inst  <= imem_data;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + AW'(4);
          end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: begin
          if (redirect_valid) begin
            if (misaligned) begin
              trap_pc_q <= redirect_pc;
            end else begin
              trap_q <= 1'b0;
              pc     <= redirect_pc;
              state  <= FETCH;
            end
          end
        end
`endif

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an accepted-instruction
// scoreboard. Honours FETCH_MISALIGN_TRAP_EN for the trap scenario.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic        trap_valid;
  logic [31:0] trap_pc;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_unit #(
    .AW       (32),
    .DW       (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc)
  );

  // instruction memory model: distinct word per address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
  endfunction

  assign imem_data = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every handshake that decode will complete at the next edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_accept: observed pc %h expected none", out_pc);
      end else begin
        sb_e = exp_q.pop_front();
        chk("acc_pc", out_pc, sb_e);
        chk("acc_inst", out_inst, mem(sb_e));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    out_ready      = 1'b0;

    // reset values
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_inst", out_inst, NOP);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_trap", trap_valid, 0);
    chk("rst_trap_pc", trap_pc, 0);

    // streaming with out_ready high: 0,4,8,C accepted
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    out_ready = 1'b1;
    @(negedge clk) rst = 1'b0;
    step();
    chk("boot_valid", out_valid, 0);
    step();
    chk("s1_valid", out_valid, 1);
    chk("s1_pc0", out_pc, 32'h0);
    step(); chk("s1_pc4", out_pc, 32'h4);
    step(); chk("s1_pc8", out_pc, 32'h8);
    step(); chk("s1_pcC", out_pc, 32'hC);
    step();
    chk("s1_count", fetch_count, 4);
    out_ready = 1'b0;

    // asynchronous reset mid-operation
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_count", fetch_count, 0);
    chk("arst_inst", out_inst, NOP);

    // stall for 3 cycles after the first capture
    exp_q.push_back(32'h0);
    @(negedge clk) rst = 1'b0;
    step();
    step();
    chk("s2_valid", out_valid, 1);
    chk("s2_pc", out_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", out_pc, 32'h0);
      chk("stall_inst", out_inst, mem(32'h0));
      chk("stall_addr", imem_addr, 32'h4);
    end
    out_ready = 1'b1;
    step();
    chk("rel_pc", out_pc, 32'h4);
    chk("rel_addr", imem_addr, 32'h8);
    out_ready = 1'b0;

    // redirect flushes a slot that decode is accepting in the same cycle
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    chk("rd_valid", out_valid, 0);
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_count", fetch_count, 1);
    chk("rd_inst", out_inst, NOP);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h100);
    step();
    chk("rd_pc", out_pc, 32'h100);
    chk("rd_valid2", out_valid, 1);
    step();
    chk("rd_count2", fetch_count, 2);

    // halt for 5 cycles with a pending slot
    out_ready = 1'b0;
    halt_req  = 1'b1;
    step();
    chk("h_halted", halted, 1);
    chk("h_valid", out_valid, 1);
    chk("h_pc", out_pc, 32'h104);
    chk("h_addr", imem_addr, 32'h108);
    exp_q.push_back(32'h104);
    out_ready = 1'b1;
    step();
    chk("h_drain", out_valid, 0);
    chk("h_count", fetch_count, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("h_hold_addr", imem_addr, 32'h108);
      chk("h_hold_halted", halted, 1);
      chk("h_hold_valid", out_valid, 0);
    end
    halt_req = 1'b0;
    exp_q.push_back(32'h108);
    step();
    chk("h_exit", halted, 0);
    chk("h_exit_valid", out_valid, 0);
    step();
    chk("h_resume_pc", out_pc, 32'h108);
    step();
    chk("h_count2", fetch_count, 4);

    // pc wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    chk("w_count", fetch_count, 4);
    redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    step();
    chk("w_pc_top", out_pc, 32'hFFFF_FFFC);
    chk("w_addr0", imem_addr, 32'h0);
    step();
    chk("w_pc0", out_pc, 32'h0);
    step();
    chk("w_count2", fetch_count, 6);

    // misaligned redirect
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk("m_valid", out_valid, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("m_trap", trap_valid, 1);
    chk("m_trap_pc", trap_pc, 32'h102);
    chk("m_addr", imem_addr, 32'h8);
    step();
    chk("m_trap_hold", trap_valid, 1);
    chk("m_nofetch", out_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    exp_q.push_back(32'h200);
    step();
    redirect_valid = 1'b0;
    chk("m_clear", trap_valid, 0);
    chk("m_addr2", imem_addr, 32'h200);
    step();
    chk("m_pc", out_pc, 32'h200);
    step();
`else
    chk("m_notrap", trap_valid, 0);
    chk("m_trap_pc", trap_pc, 0);
    chk("m_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    step();
    chk("m_pc", out_pc, 32'h100);
    chk("m_notrap2", trap_valid, 0);
    step();
`endif
    out_ready = 1'b0;
    chk("end_count", fetch_count, 7);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
